// File: rtl/fdc_dfc_stimulus.sv
// Digital-to-frequency stimulus: phase accumulator square wave, reference gate,
// and a per-window rising-edge counter that predicts the FDC result.
module fdc_dfc_stimulus #(
    parameter int ACC_W   = 16,
    parameter int WORD_W  = 5,
    parameter int SHIFT   = 8,
    parameter int REF_DIV = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WORD_W-1:0] word_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              vco_out,
    output logic              ref_out,
    output logic [WORD_W-1:0] word_active,
    output logic [WORD_W-1:0] cnt_out,
    output logic              cnt_valid,
    output logic              cnt_sat
);

    localparam int RC_W = $clog2(REF_DIV);
    localparam logic [RC_W-1:0]   REF_LAST = RC_W'(REF_DIV - 1);
    localparam logic [WORD_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SWAP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [RC_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic              ref_q, ref_d;
    logic              vco_prev_q, vco_prev_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] pend_q, pend_d;
    logic [WORD_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              edge_sat_q, edge_sat_d;
    logic [WORD_W-1:0] cnt_out_q, cnt_out_d;
    logic              cnt_sat_q, cnt_sat_d;
    logic              cnt_valid_q, cnt_valid_d;

    logic [ACC_W-1:0]  inc;
    logic [ACC_W:0]    sum;
    logic              xfer;
    logic              ref_wrap;
    logic              rise;
    logic [WORD_W-1:0] cnt_inc;
    logic              sat_inc;

    assign load_ready  = (state_q != S_SWAP);
    assign vco_out     = acc_q[ACC_W-1];
    assign ref_out     = ref_q;
    assign word_active = word_q;
    assign cnt_out     = cnt_out_q;
    assign cnt_valid   = cnt_valid_q;
    assign cnt_sat     = cnt_sat_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ref_cnt_d   = ref_cnt_q;
        ref_d       = ref_q;
        vco_prev_d  = vco_prev_q;
        word_d      = word_q;
        pend_d      = pend_q;
        edge_cnt_d  = edge_cnt_q;
        edge_sat_d  = edge_sat_q;
        cnt_out_d   = cnt_out_q;
        cnt_sat_d   = cnt_sat_q;
        cnt_valid_d = 1'b0;

        inc      = ACC_W'({word_q, {SHIFT{1'b0}}});
        sum      = {1'b0, acc_q} + {1'b0, inc};
        xfer     = load_valid & load_ready;
        ref_wrap = (ref_cnt_q == REF_LAST);
        rise     = acc_q[ACC_W-1] & ~vco_prev_q;

        // Count including an edge seen in this cycle, so a window-closing edge is not lost.
        cnt_inc = edge_cnt_q;
        sat_inc = edge_sat_q;
        if (ref_q && rise) begin
            if (edge_cnt_q == CNT_MAX) sat_inc = 1'b1;
            else                       cnt_inc = edge_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (xfer) word_d = word_in;
                if (enable) begin
                    state_d    = S_RUN;
                    acc_d      = '0;
                    ref_cnt_d  = '0;
                    ref_d      = 1'b0;
                    vco_prev_d = 1'b0;
                    edge_cnt_d = '0;
                    edge_sat_d = 1'b0;
                end
            end
            default: begin
                if (!enable) begin
                    state_d    = S_IDLE;
                    acc_d      = '0;
                    ref_cnt_d  = '0;
                    ref_d      = 1'b0;
                    vco_prev_d = 1'b0;
                    pend_d     = '0;
                end else begin
                    acc_d      = sum[ACC_W-1:0];
                    vco_prev_d = acc_q[ACC_W-1];
                    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + 1'b1;
                    edge_cnt_d = cnt_inc;
                    edge_sat_d = sat_inc;
                    if (ref_wrap) begin
                        ref_d = ~ref_q;
                        if (ref_q) begin
                            cnt_out_d   = cnt_inc;
                            cnt_sat_d   = sat_inc;
                            cnt_valid_d = 1'b1;
                        end else begin
                            edge_cnt_d = '0;
                            edge_sat_d = 1'b0;
                        end
                    end
                    // Swapping only on carry-out keeps the output free of short pulses.
                    if (state_q == S_SWAP) begin
                        if (sum[ACC_W]) begin
                            word_d  = pend_q;
                            state_d = S_RUN;
                        end
                    end else if (xfer) begin
                        pend_d  = word_in;
                        state_d = S_SWAP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            ref_cnt_q   <= '0;
            ref_q       <= 1'b0;
            vco_prev_q  <= 1'b0;
            word_q      <= '0;
            pend_q      <= '0;
            edge_cnt_q  <= '0;
            edge_sat_q  <= 1'b0;
            cnt_out_q   <= '0;
            cnt_sat_q   <= 1'b0;
            cnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_q       <= ref_d;
            vco_prev_q  <= vco_prev_d;
            word_q      <= word_d;
            pend_q      <= pend_d;
            edge_cnt_q  <= edge_cnt_d;
            edge_sat_q  <= edge_sat_d;
            cnt_out_q   <= cnt_out_d;
            cnt_sat_q   <= cnt_sat_d;
            cnt_valid_q <= cnt_valid_d;
        end
    end

endmodule

// File: tb/tb_fdc_dfc_stimulus.sv
// Bench for fdc_dfc_stimulus: two instances (REF_DIV 256 and 512) share stimulus and are
// compared every cycle against a time-based model, plus hand-computed spot values.
module tb_fdc_dfc_stimulus;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [4:0] word_in;
    logic       load_valid;

    logic       rdy_o [2];
    logic       vco_o [2];
    logic       ref_o [2];
    logic [4:0] wa_o  [2];
    logic [4:0] co_o  [2];
    logic       val_o [2];
    logic       sat_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fdc_dfc_stimulus #(.ACC_W(16), .WORD_W(5), .SHIFT(8), .REF_DIV(256)) dut (
        .clk(clk), .reset(reset), .enable(enable), .word_in(word_in),
        .load_valid(load_valid), .load_ready(rdy_o[0]), .vco_out(vco_o[0]),
        .ref_out(ref_o[0]), .word_active(wa_o[0]), .cnt_out(co_o[0]),
        .cnt_valid(val_o[0]), .cnt_sat(sat_o[0])
    );

    fdc_dfc_stimulus #(.ACC_W(16), .WORD_W(5), .SHIFT(8), .REF_DIV(512)) dut512 (
        .clk(clk), .reset(reset), .enable(enable), .word_in(word_in),
        .load_valid(load_valid), .load_ready(rdy_o[1]), .vco_out(vco_o[1]),
        .ref_out(ref_o[1]), .word_active(wa_o[1]), .cnt_out(co_o[1]),
        .cnt_valid(val_o[1]), .cnt_sat(sat_o[1])
    );

    // Model: time since RUN entry drives the ref gate; phase is a plain integer;
    // edges are counted unbounded and clipped only when reported.
    int rd [2] = '{256, 512};
    bit m_ok = 0;
    bit m_idle [2];
    bit m_swap [2];
    int m_word [2];
    int m_pend [2];
    int m_phase[2];
    int m_t    [2];
    bit m_prev [2];
    int m_cnt  [2];
    int e_co   [2];
    bit e_sat  [2];
    bit e_val  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_idle[k] = 1; m_swap[k] = 0; m_word[k] = 0; m_pend[k] = 0;
                m_phase[k] = 0; m_t[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
                e_co[k] = 0; e_sat[k] = 0; e_val[k] = 0;
            end else begin
                bit xfer, vnow, rnow, carry;
                int np;
                e_val[k] = 0;
                xfer = load_valid && !m_swap[k];
                if (m_idle[k]) begin
                    if (xfer) m_word[k] = int'(word_in);
                    if (enable) begin
                        m_idle[k] = 0; m_phase[k] = 0; m_t[k] = 0; m_prev[k] = 0; m_cnt[k] = 0;
                    end
                end else if (!enable) begin
                    m_idle[k] = 1; m_swap[k] = 0; m_pend[k] = 0;
                    m_phase[k] = 0; m_t[k] = 0; m_prev[k] = 0;
                end else begin
                    vnow = (m_phase[k] >= 32768);
                    rnow = ((m_t[k] / rd[k]) % 2) == 1;
                    if (rnow && vnow && !m_prev[k]) m_cnt[k]++;
                    if ((m_t[k] % rd[k]) == rd[k] - 1) begin
                        if (rnow) begin
                            e_co[k]  = (m_cnt[k] > 31) ? 31 : m_cnt[k];
                            e_sat[k] = (m_cnt[k] > 31);
                            e_val[k] = 1;
                        end else begin
                            m_cnt[k] = 0;
                        end
                    end
                    np = m_phase[k] + m_word[k] * 256;
                    carry = (np >= 65536);
                    m_phase[k] = np % 65536;
                    m_prev[k] = vnow;
                    m_t[k]++;
                    if (m_swap[k]) begin
                        if (carry) begin
                            m_word[k] = m_pend[k];
                            m_swap[k] = 0;
                        end
                    end else if (xfer) begin
                        m_pend[k] = int'(word_in);
                        m_swap[k] = 1;
                    end
                end
            end
        end
        if (reset) m_ok = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d.load_ready", k), int'(rdy_o[k]), int'(!m_swap[k]));
                chk($sformatf("m%0d.vco_out", k), int'(vco_o[k]),
                    int'(!m_idle[k] && m_phase[k] >= 32768));
                chk($sformatf("m%0d.ref_out", k), int'(ref_o[k]),
                    int'(!m_idle[k] && ((m_t[k] / rd[k]) % 2) == 1));
                chk($sformatf("m%0d.word_active", k), int'(wa_o[k]), m_word[k]);
                chk($sformatf("m%0d.cnt_out", k), int'(co_o[k]), e_co[k]);
                chk($sformatf("m%0d.cnt_sat", k), int'(sat_o[k]), int'(e_sat[k]));
                chk($sformatf("m%0d.cnt_valid", k), int'(val_o[k]), int'(e_val[k]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench observing cycle 0 of a fresh RUN period.
    task automatic restart_with(input int w);
        enable = 0;
        step(1);
        word_in = 5'(w); load_valid = 1;
        step(1);
        load_valid = 0; enable = 1;
        step(1);
    endtask

    initial begin
        int c;
        reset = 1; enable = 1; word_in = 0; load_valid = 0;
        step(3);
        chk("T1.load_ready", int'(rdy_o[0]), 1);
        chk("T1.vco_out", int'(vco_o[0]), 0);
        chk("T1.ref_out", int'(ref_o[0]), 0);
        chk("T1.cnt_valid", int'(val_o[0]), 0);
        chk("T1.word_active", int'(wa_o[0]), 0);
        reset = 0; enable = 0;

        // T2: word 16 loaded in IDLE, then run
        step(1);
        word_in = 5'd16; load_valid = 1;
        step(1);
        load_valid = 0;
        chk("T2.word_idle_load", int'(wa_o[0]), 16);
        enable = 1;
        step(1);
        chk("T2.vco_c0", int'(vco_o[0]), 0);
        step(7);
        chk("T2.vco_c7", int'(vco_o[0]), 0);
        step(1);
        chk("T2.vco_c8", int'(vco_o[0]), 1);
        step(503);
        chk("T2.valid_c511", int'(val_o[0]), 0);
        step(1);
        chk("T2.valid_c512", int'(val_o[0]), 1);
        chk("T2.cnt_c512", int'(co_o[0]), 16);
        chk("T2.sat_c512", int'(sat_o[0]), 0);
        step(512);
        chk("T4.valid_c1024", int'(val_o[1]), 1);
        chk("T4.cnt_c1024", int'(co_o[1]), 31);
        chk("T4.sat_c1024", int'(sat_o[1]), 1);

        // T6: disable mid-window, then re-enable
        step(276);
        chk("T6.ref_c1300", int'(ref_o[0]), 1);
        enable = 0;
        step(1);
        chk("T6.ref_off", int'(ref_o[0]), 0);
        chk("T6.vco_off", int'(vco_o[0]), 0);
        chk("T6.no_valid", int'(val_o[0]), 0);
        chk("T6.cnt_kept", int'(co_o[0]), 16);
        enable = 1;
        step(1);
        step(7);
        chk("T6.vco_c7", int'(vco_o[0]), 0);
        step(1);
        chk("T6.vco_c8", int'(vco_o[0]), 1);
        step(247);
        chk("T6.ref_c255", int'(ref_o[0]), 0);
        step(1);
        chk("T6.ref_c256", int'(ref_o[0]), 1);

        // T5: word 1 running, load 8 mid-period, swap waits for the carry
        restart_with(1);
        chk("T5.word_c0", int'(wa_o[0]), 1);
        step(40);
        word_in = 5'd8; load_valid = 1;
        step(1);
        load_valid = 0;
        chk("T5.ready_low", int'(rdy_o[0]), 0);
        chk("T5.word_old", int'(wa_o[0]), 1);
        c = 41;
        while (wa_o[0] != 5'd8 && c < 400) begin
            step(1);
            c++;
        end
        chk("T5.swap_cycle", c, 256);
        chk("T5.ready_back", int'(rdy_o[0]), 1);

        // T3: word 0 holds vco low, windows report zero
        restart_with(0);
        step(511);
        chk("T3.vco_low", int'(vco_o[0]), 0);
        step(1);
        chk("T3.valid", int'(val_o[0]), 1);
        chk("T3.cnt_zero", int'(co_o[0]), 0);
        chk("T3.sat_zero", int'(sat_o[0]), 0);

        // Randomized operation against the model
        for (int i = 0; i < 15000; i++) begin
            step(1);
            reset      = ($urandom % 6000) == 0;
            load_valid = ($urandom % 20) == 0;
            word_in    = 5'($urandom % 32);
            if (!enable && ($urandom % 8) == 0) enable = 1;
            else if (enable && ($urandom % 400) == 0) enable = 0;
        end
        reset = 0; load_valid = 0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
